// File: rtl/branch_predictor_btb.sv
// Branch target buffer with per-entry saturating direction counters.
// Zero-latency fetch lookup, ID-stage training, and saturating performance counters.
module branch_predictor_btb #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              startin,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              mispredict,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_ONE        = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_WEAK_TAKEN = CTR_ONE << (CTR_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

    // Lookup reads registered state only, so a same-cycle update is not visible.
    assign pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = pred_hit && ctr_q[if_idx][CTR_W-1];
    assign pred_target = pred_hit ? target_q[if_idx] : '0;

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign mispredict = upd_valid &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));

    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[upd_idx] != '1)
                        ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_ONE;
                    target_q[upd_idx] <= upd_target;
                end else if (ctr_q[upd_idx] != '0) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_ONE;
                end
            end else if (upd_taken) begin
                // Allocation replaces whatever aliasing entry sits at this index.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= CTR_WEAK_TAKEN;
            end
        end
    end

    always_ff @(posedge clk or negedge startin) begin
        if (!startin) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (upd_valid && (branch_cnt != '1))
                branch_cnt <= branch_cnt + CNT_ONE;
            if (mispredict && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + CNT_ONE;
        end
    end

endmodule
